// File: rtl/hdmi_sync_gen_if.sv
// Signal bundle between the video analyzer / downstream consumers and the HDMI timing generator.
// The generator sits on the slave side; the master drives mode/vreset and observes timing.
interface hdmi_sync_gen_if;
    logic [1:0] mode;
    logic       vreset;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       frame_start;
    logic       pal;

    modport master (
        output mode, vreset,
        input  x, y, hs, vs, de, frame_start, pal
    );

    modport slave (
        input  mode, vreset,
        output x, y, hs, vs, de, frame_start, pal
    );
endinterface

// File: rtl/hdmi_sync_gen.sv
// 720-wide progressive timing generator (576p50 / 480p60) with vreset realignment to the
// C64 source. All outputs are registered and decoded from the next-state counters.
module hdmi_sync_gen #(
    parameter bit SYNC_POL = 1'b0
) (
    input logic           clk,
    input logic           reset,
    hdmi_sync_gen_if.slave bus
);
    localparam logic [9:0] H_ACT = 10'd720;

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       pal_q, pal_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       de_q, de_d;
    logic       fs_q, fs_d;

    logic [9:0] h_last, v_last;
    logic [9:0] hs_b, hs_e, vs_b, vs_e, v_act;
    logic       line_end, frame_end;

    always_comb begin
        h_last    = pal_q ? 10'd863 : 10'd857;
        v_last    = pal_q ? 10'd624 : 10'd524;
        // >= rather than == so a counter can never run past its total
        line_end  = (x_q >= h_last);
        frame_end = line_end && (y_q >= v_last);

        x_d   = x_q + 10'd1;
        y_d   = y_q;
        pal_d = pal_q;
        if (bus.vreset || frame_end) begin
            x_d   = 10'd0;
            y_d   = 10'd0;
            pal_d = (bus.mode != 2'd0);
        end else if (line_end) begin
            x_d = 10'd0;
            y_d = y_q + 10'd1;
        end

        // Decode against the set the next cycle will be in, so a switch lands on x=0,y=0
        hs_b  = pal_d ? 10'd732 : 10'd736;
        hs_e  = pal_d ? 10'd795 : 10'd797;
        vs_b  = pal_d ? 10'd581 : 10'd489;
        vs_e  = pal_d ? 10'd585 : 10'd494;
        v_act = pal_d ? 10'd576 : 10'd480;

        hs_d = ((x_d >= hs_b) && (x_d <= hs_e)) ? SYNC_POL : ~SYNC_POL;
        vs_d = ((y_d >= vs_b) && (y_d <= vs_e)) ? SYNC_POL : ~SYNC_POL;
        de_d = (x_d < H_ACT) && (y_d < v_act);
        fs_d = (x_d == 10'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q   <= 10'd863;
            y_q   <= 10'd624;
            pal_q <= 1'b1;
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            de_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            pal_q <= pal_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            fs_q  <= fs_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.pal         = pal_q;
    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.de          = de_q;
    assign bus.frame_start = fs_q;
endmodule

// File: doc/hdmi_sync_gen.md
# hdmi_sync_gen

Video timing generator for the HDMI output path. It consumes `mode` and the one-cycle `vreset` pulse from the upstream video analyzer. It produces 720-wide progressive timing (576p50 for PAL, 480p60 for NTSC) with pixel coordinates for the scaler and TMDS encoder. `vreset` realigns the counters to the first visible pixel, so HDMI frames track the C64 video source.

## Interface
Parameters:
- `SYNC_POL`, default 0: polarity of `hs`/`vs` while in sync. 0 means active-low, which is CEA 480p/576p.

Ports:
- `clk`  in  1  pixel clock (27 MHz); all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `mode`  in  2  0=NTSC, 1=PAL, 2=mono, 3=reserved; from the analyzer
- `vreset`  in  1  one-cycle pulse that forces the counters to the first active pixel
- `x`  out  10  horizontal counter; 0 = first active pixel
- `y`  out  10  vertical counter; 0 = first active line
- `hs`  out  1  horizontal sync, polarity per `SYNC_POL`
- `vs`  out  1  vertical sync, polarity per `SYNC_POL`
- `de`  out  1  data enable; high in the active area
- `frame_start`  out  1  one-cycle pulse when `x`=0 and `y`=0
- `pal`  out  1  timing set currently in use; 1 = 576p50

## Operation
Two timing sets are selected by the latched mode `pal`:
- PAL: h_total 864, h_active 720, hsync x 732..795 (FP 12, sync 64, BP 68).
  - v_total 625, v_active 576, vsync y 581..585 (FP 5, sync 5, BP 39).
- NTSC: h_total 858, h_active 720, hsync x 736..797 (FP 16, sync 62, BP 60).
  - v_total 525, v_active 480, vsync y 489..494 (FP 9, sync 6, BP 30).

Counters:
- `x` increments every cycle and wraps h_total-1 → 0.
- On that wrap, `y` increments and wraps v_total-1 → 0.
- Counters are unsigned 10-bit. No state exceeds its total.

Output decode:
- `de` = (`x` < 720) && (`y` < v_active).
- `hs` is in sync while `x` is inside the hsync range.
- `vs` is in sync while `y` is inside the vsync range. It changes only at `x`=0 transitions.

Mode latch:
- `mode` is sampled only at the frame wrap (`x`=h_total-1, `y`=v_total-1) and on `vreset`.
- `pal` ← (`mode` != 0), so mono and reserved use PAL timing.
- A mid-frame `mode` change takes effect at the next frame boundary.

`vreset`:
- The cycle after `vreset` is sampled high: `x`=0, `y`=0, `de`=1, `frame_start`=1, and `pal` is reloaded from `mode`.
- `vreset` has priority over normal counting and over the frame wrap. Simultaneous assertion gives the same result as a normal wrap.
- `vreset` while already at `x`=h_total-1, `y`=v_total-1 produces exactly one `frame_start`, not two.

## Timing
- Reset (asynchronous, effective immediately):
  - `x`=863, `y`=624, `pal`=1, `de`=0, `frame_start`=0, `hs`/`vs` inactive.
  - First rising edge after release: `x`=0, `y`=0, `de`=1, `frame_start`=1.
- All outputs are registered. `hs`/`vs`/`de`/`frame_start` are decoded from the next-state counters, so they align with `x`/`y` in the same cycle. There is no extra pipeline delay.
- Latency from `vreset` to `x`=0: 1 cycle.
- Reset asserted mid-line or mid-frame returns everything to the reset values. There is no partial state.
- `frame_start` period:
  - PAL: 540000 cycles.
  - NTSC: 450450 cycles.
  - Both hold absent `vreset`.
- On a timing-set switch, the last frame in the old set completes intact. The first frame in the new set starts at `x`=0, `y`=0.

## Test plan
- Reset, then release with `mode`=1 → `x`=863, `y`=624, `de`=0 during reset. One cycle after release: `x`=0, `y`=0, `de`=1, `frame_start`=1.
- `mode`=1, free-running → consecutive `frame_start` pulses 540000 cycles apart.
  - `hs` low for exactly 64 cycles starting at `x`=732.
  - `vs` low for lines 581..585.
  - `de` high for 720×576 cycles per frame.
- Switch `mode` 1→0 at `y`=100 → current frame still 540000 cycles. The following frame is 450450 cycles, with `hs` low at `x`=736..797 and `pal`=0.
- `vreset` pulse at `x`=300, `y`=100 → next cycle `x`=0, `y`=0, `de`=1, `frame_start`=1. Next `frame_start` follows 540000 cycles later (PAL).
- `mode`=2 with `vreset` → `pal`=1 and PAL totals used. `vreset` coincident with the frame wrap → a single `frame_start` pulse.
- Assert `reset` at `x`=500, `y`=300 for 3 cycles → outputs return to reset values asynchronously, then restart as in the first scenario.
